key_freq_ctrl: RTL and testbench

KEY_FREQ_CTRL -- requirements
Module: key_freq_ctrl

---
 rtl/key_freq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_key_freq_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/key_freq_ctrl.sv
// Key-driven frequency tuning word controller for a DDS.
// Up/down keys adjust the tuning word by a selectable decade step, with
// long-press auto-repeat; the step key cycles the decade exponent 0..5.

// Per-key press/long-press/repeat sequencer for the up and down keys.
module key_repeat_fsm #(
    parameter logic [31:0] LONG_CYC = 32'd50_000_000,
    parameter logic [31:0] REP_CYC  = 32'd10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic evt
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        REPEAT
    } state_t;

    state_t      state;
    logic        prev;
    logic [31:0] cnt;
    logic        press;
    logic        rep_hit;

    // The counter holds cycles elapsed since the last event minus one, so an
    // event fires on the edge where the counter would reach the interval.
    always_comb begin
        press   = prev & ~key;
        rep_hit = 1'b0;
        case (state)
            PRESS:   rep_hit = ~key && ((cnt + 32'd1) == LONG_CYC);
            REPEAT:  rep_hit = ~key && ((cnt + 32'd1) == REP_CYC);
            default: rep_hit = 1'b0;
        endcase
        evt = press | rep_hit;
    end

    // Sample history, state and hold counter; a released key always returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= 1'b0;
            state <= IDLE;
            cnt   <= 32'd0;
        end else begin
            prev <= key;
            if (key) begin
                state <= IDLE;
                cnt   <= 32'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (press) begin
                            state <= PRESS;
                            cnt   <= 32'd0;
                        end
                    end
                    PRESS: begin
                        if (rep_hit) begin
                            state <= REPEAT;
                            cnt   <= 32'd0;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    REPEAT: begin
                        if (rep_hit) begin
                            cnt <= 32'd0;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= 32'd0;
                    end
                endcase
            end
        end
    end

endmodule

module key_freq_ctrl #(
    parameter logic [31:0] FW_INIT  = 32'd1000,
    parameter logic [31:0] FW_MIN   = 32'd1,
    parameter logic [31:0] FW_MAX   = 32'd100_000_000,
    parameter logic [31:0] FW_UNIT  = 32'd1,
    parameter logic [31:0] LONG_CYC = 32'd50_000_000,
    parameter logic [31:0] REP_CYC  = 32'd10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_up,
    input  logic        key_dn,
    input  logic        key_step,
    output logic [31:0] fword,
    output logic [2:0]  step_idx,
    output logic        fword_vld
);

    logic        up_evt;
    logic        dn_evt;
    logic        step_prev;
    logic        step_evt;
    logic [31:0] step_val;
    logic [32:0] sum_wide;
    logic [32:0] floor_wide;
    logic [31:0] next_fword;

    key_repeat_fsm #(
        .LONG_CYC (LONG_CYC),
        .REP_CYC  (REP_CYC)
    ) u_up (
        .clk (clk),
        .rst (rst),
        .key (key_up),
        .evt (up_evt)
    );

    key_repeat_fsm #(
        .LONG_CYC (LONG_CYC),
        .REP_CYC  (REP_CYC)
    ) u_dn (
        .clk (clk),
        .rst (rst),
        .key (key_dn),
        .evt (dn_evt)
    );

    // Decade step table indexed by the current (pre-update) step exponent.
    always_comb begin
        step_evt = step_prev & ~key_step;
        case (step_idx)
            3'd0:    step_val = FW_UNIT;
            3'd1:    step_val = FW_UNIT * 32'd10;
            3'd2:    step_val = FW_UNIT * 32'd100;
            3'd3:    step_val = FW_UNIT * 32'd1000;
            3'd4:    step_val = FW_UNIT * 32'd10000;
            3'd5:    step_val = FW_UNIT * 32'd100000;
            default: step_val = FW_UNIT;
        endcase
    end

    // Saturating tuning-word arithmetic in 33 bits; simultaneous up and down cancel.
    always_comb begin
        sum_wide   = {1'b0, fword} + {1'b0, step_val};
        floor_wide = {1'b0, FW_MIN} + {1'b0, step_val};
        next_fword = fword;
        if (up_evt && !dn_evt) begin
            if (sum_wide > {1'b0, FW_MAX}) begin
                next_fword = FW_MAX;
            end else begin
                next_fword = sum_wide[31:0];
            end
        end else if (dn_evt && !up_evt) begin
            if ({1'b0, fword} < floor_wide) begin
                next_fword = FW_MIN;
            end else begin
                next_fword = fword - step_val;
            end
        end
    end

    // Registered outputs: tuning word, change pulse and step exponent.
    always_ff @(posedge clk) begin
        if (rst) begin
            fword     <= FW_INIT;
            fword_vld <= 1'b0;
            step_idx  <= 3'd0;
            step_prev <= 1'b0;
        end else begin
            fword     <= next_fword;
            fword_vld <= (next_fword != fword);
            step_prev <= key_step;
            if (step_evt) begin
                step_idx <= (step_idx == 3'd5) ? 3'd0 : step_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_key_freq_ctrl.sv
// Scoreboard bench for key_freq_ctrl with small timing parameters.
module tb_key_freq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_up = 1'b1;
    logic        key_dn = 1'b1;
    logic        key_step = 1'b1;
    logic [31:0] fword;
    logic [2:0]  step_idx;
    logic        fword_vld;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_word;

    key_freq_ctrl #(
        .FW_INIT  (32'd100),
        .FW_MIN   (32'd10),
        .FW_MAX   (32'd1000),
        .FW_UNIT  (32'd1),
        .LONG_CYC (32'd20),
        .REP_CYC  (32'd5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_up    (key_up),
        .key_dn    (key_dn),
        .key_step  (key_step),
        .fword     (fword),
        .step_idx  (step_idx),
        .fword_vld (fword_vld)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic up, input logic dn, input logic st, input int n);
        key_up   = up;
        key_dn   = dn;
        key_step = st;
        tick(n);
    endtask

    task automatic checkDrained(input string name);
        tick(2);
        checkOutput(name, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic doReset(input string name);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 2);
        rst = 1'b0;
        tick(1);
        checkOutput({name, "_rst_fword"}, fword, 32'd100);
        checkOutput({name, "_rst_step"}, step_idx, 32'd0);
        checkOutput({name, "_rst_vld"}, fword_vld, 32'd0);
    endtask

    // Monitor: every fword_vld pulse must match the next expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && fword_vld) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_vld", fword, 32'hFFFF_FFFF);
                end else begin
                    exp_word = exp_q.pop_front();
                    checkOutput("vld_fword", fword, exp_word);
                end
            end
        end
    end

    initial begin
        doReset("t1");
        exp_q.push_back(32'd101);
        applyStimulus(1'b0, 1'b1, 1'b1, 3);
        applyStimulus(1'b1, 1'b1, 1'b1, 3);
        checkOutput("single_up_fword", fword, 32'd101);
        checkDrained("single_up_pending");

        doReset("t2");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1);
            applyStimulus(1'b1, 1'b1, 1'b1, 1);
        end
        checkOutput("step_twice_idx", step_idx, 32'd2);
        exp_q.push_back(32'd200);
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 2);
        checkOutput("step_up_fword", fword, 32'd200);
        checkDrained("step_up_pending");

        doReset("t3");
        exp_q.push_back(32'd101);
        exp_q.push_back(32'd102);
        exp_q.push_back(32'd103);
        exp_q.push_back(32'd104);
        applyStimulus(1'b0, 1'b1, 1'b1, 20);
        checkOutput("hold_before_long", fword, 32'd101);
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        checkOutput("hold_first_repeat", fword, 32'd102);
        applyStimulus(1'b0, 1'b1, 1'b1, 4);
        checkOutput("hold_repeat_gap", fword, 32'd102);
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        checkOutput("hold_second_repeat", fword, 32'd103);
        applyStimulus(1'b0, 1'b1, 1'b1, 5);
        applyStimulus(1'b1, 1'b1, 1'b1, 3);
        checkOutput("hold_final_fword", fword, 32'd104);
        checkDrained("hold_pending");

        doReset("t4");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1);
            applyStimulus(1'b1, 1'b1, 1'b1, 1);
        end
        exp_q.push_back(32'd10);
        applyStimulus(1'b1, 1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 2);
        checkOutput("dn_clamp_fword", fword, 32'd10);
        applyStimulus(1'b1, 1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 2);
        checkOutput("dn_floor_fword", fword, 32'd10);
        checkDrained("dn_pending");

        doReset("t5");
        applyStimulus(1'b0, 1'b0, 1'b1, 3);
        applyStimulus(1'b1, 1'b1, 1'b1, 2);
        checkOutput("up_dn_cancel_fword", fword, 32'd100);
        checkDrained("up_dn_pending");

        doReset("t6");
        exp_q.push_back(32'd101);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        checkOutput("old_step_idx", step_idx, 32'd1);
        checkOutput("old_step_fword", fword, 32'd101);
        exp_q.push_back(32'd111);
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        checkOutput("new_step_fword", fword, 32'd111);
        checkDrained("old_step_pending");

        doReset("t7");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1);
            applyStimulus(1'b1, 1'b1, 1'b1, 1);
        end
        checkOutput("step_max_idx", step_idx, 32'd5);
        exp_q.push_back(32'd1000);
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        checkOutput("sat_max_fword", fword, 32'd1000);
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        checkOutput("sat_hold_fword", fword, 32'd1000);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        checkOutput("step_wrap_idx", step_idx, 32'd0);
        checkDrained("sat_pending");

        doReset("t8");
        exp_q.push_back(32'd101);
        exp_q.push_back(32'd102);
        applyStimulus(1'b0, 1'b1, 1'b1, 22);
        checkOutput("abort_pre_fword", fword, 32'd102);
        checkOutput("abort_pre_pending", exp_q.size(), 32'd0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1, 50);
        checkOutput("abort_held_fword", fword, 32'd100);
        checkDrained("abort_held_pending");
        applyStimulus(1'b1, 1'b1, 1'b1, 2);
        exp_q.push_back(32'd101);
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 2);
        checkOutput("abort_repress_fword", fword, 32'd101);
        checkDrained("abort_repress_pending");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
